// File: rtl/upg_stream_loader_if.sv
// Byte-in / word-write bundle between the UART receiver, the loader and the memory programmer ports.
// The slave modport is the loader; the master modport is the feeder/observer side.
interface upg_stream_loader_if #(
   parameter int unsigned ADDR_W = 14
);
   logic [7:0]        rx_dat_i;
   logic              rx_vld_i;
   logic              upg_wen_o;
   logic [ADDR_W-1:0] upg_adr_o;
   logic [31:0]       upg_dat_o;
   logic              upg_sel_o;
   logic              upg_done_o;
   logic              upg_err_o;

   modport master (
      output rx_dat_i, rx_vld_i,
      input  upg_wen_o, upg_adr_o, upg_dat_o, upg_sel_o, upg_done_o, upg_err_o
   );

   modport slave (
      input  rx_dat_i, rx_vld_i,
      output upg_wen_o, upg_adr_o, upg_dat_o, upg_sel_o, upg_done_o, upg_err_o
   );
endinterface

// File: rtl/upg_stream_loader.sv
// Parses a TGT/CNT_LO/CNT_HI header from the UART byte stream and writes the following payload
// as little-endian 32-bit words at sequential word addresses into the selected memory.
module upg_stream_loader #(
   parameter int unsigned ADDR_W      = 14,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input logic               upg_clk_i,
   input logic               upg_rst_i,
   upg_stream_loader_if.slave bus
);

   localparam int unsigned     MaxWords = 1 << ADDR_W;
   localparam int unsigned     TmoW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {StTgt, StClo, StChi, StData, StDone, StErr} state_e;

   state_e            state_q;
   logic [15:0]       cnt_q;
   logic [1:0]        idx_q;
   logic [23:0]       lane_q;
   logic [ADDR_W:0]   wcnt_q;
   logic [TmoW-1:0]   tmo_q;
   logic              wen_q;
   logic [ADDR_W-1:0] adr_q;
   logic [31:0]       dat_q;
   logic              sel_q;
   logic              done_q;
   logic              err_q;

   logic [15:0] cnt_full;
   logic        last_word;
   logic        timed_out;

   assign cnt_full  = {bus.rx_dat_i, cnt_q[7:0]};
   // wcnt_q already counts the word being pulsed, so equality marks the final pulse
   assign last_word = (32'(wcnt_q) == 32'(cnt_q));
   // An arriving byte always beats the idle limit
   assign timed_out = !bus.rx_vld_i && (tmo_q == TmoLast);

   always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
      if (upg_rst_i) begin
         state_q <= StTgt;
         cnt_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         wcnt_q  <= '0;
         tmo_q   <= '0;
         wen_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         wen_q <= 1'b0;
         tmo_q <= bus.rx_vld_i ? '0 : tmo_q + TmoW'(1);
         unique case (state_q)
            StTgt: begin
               if (bus.rx_vld_i) begin
                  if (bus.rx_dat_i == 8'h00 || bus.rx_dat_i == 8'h01) begin
                     sel_q   <= bus.rx_dat_i[0];
                     state_q <= StClo;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= StErr;
                  end
               end
            end
            StClo: begin
               if (timed_out) begin
                  err_q   <= 1'b1;
                  state_q <= StErr;
               end else if (bus.rx_vld_i) begin
                  cnt_q[7:0] <= bus.rx_dat_i;
                  state_q    <= StChi;
               end
            end
            StChi: begin
               if (timed_out) begin
                  err_q   <= 1'b1;
                  state_q <= StErr;
               end else if (bus.rx_vld_i) begin
                  cnt_q <= cnt_full;
                  if (cnt_full == 16'd0) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else if (32'(cnt_full) > MaxWords) begin
                     err_q   <= 1'b1;
                     state_q <= StErr;
                  end else begin
                     state_q <= StData;
                  end
               end
            end
            StData: begin
               if (wen_q && last_word) begin
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else if (timed_out) begin
                  err_q   <= 1'b1;
                  state_q <= StErr;
               end else if (bus.rx_vld_i) begin
                  idx_q <= idx_q + 2'd1;
                  unique case (idx_q)
                     2'd0: lane_q[7:0]   <= bus.rx_dat_i;
                     2'd1: lane_q[15:8]  <= bus.rx_dat_i;
                     2'd2: lane_q[23:16] <= bus.rx_dat_i;
                     2'd3: begin
                        wen_q  <= 1'b1;
                        dat_q  <= {bus.rx_dat_i, lane_q};
                        adr_q  <= wcnt_q[ADDR_W-1:0];
                        wcnt_q <= wcnt_q + 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            StDone, StErr: ;
            default: begin
               err_q   <= 1'b1;
               state_q <= StErr;
            end
         endcase
      end
   end

   assign bus.upg_wen_o  = wen_q;
   assign bus.upg_adr_o  = adr_q;
   assign bus.upg_dat_o  = dat_q;
   assign bus.upg_sel_o  = sel_q;
   assign bus.upg_done_o = done_q;
   assign bus.upg_err_o  = err_q;

endmodule
